aq_djpeg_mcu_seq: RTL and testbench
===================================

AQ_DJPEG_MCU_SEQ -- requirements
Module: aq_djpeg_mcu_seq

Interface
REQ-001 SHALL have parameter COMP_MAX, default 3, maximum number of components per scan (1..4).
REQ-002 SHALL have parameter W_POS, default 12, width of MCU X/Y position and MCU dimension ports.
REQ-003 SHALL have parameter W_RST, default 16, width of restart-interval counter and port.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-006 SHALL have port ProcessInit, input, 1, synchronous re-initialise pulse.
REQ-007 SHALL have port ScanStart, input, 1, pulse; latches scan configuration and starts sequencing.
REQ-008 SHALL have port ScanComp, input, 3, components in the scan (1..COMP_MAX); the value 1 means a non-interleaved scan.
REQ-009 SHALL have ports SampH and SampV, input, 2*COMP_MAX each, packed per-component sampling factors (1..3), component 0 in the LSBs.
REQ-010 SHALL have ports McuWidth and McuHeight, input, W_POS each, MCUs per row and per column.
REQ-011 SHALL have port RestartInterval, input, W_RST, MCUs per restart interval; 0 disables restart handling.
REQ-012 SHALL have port BlockDone, input, 1, pulse from the Huffman decoder marking one 8x8 block decoded.
REQ-013 SHALL have port AlignAck, input, 1, pulse marking that byte alignment is done and the RST marker has been consumed.
REQ-014 SHALL have port RstNum, input, 3, RST marker index (0..7), valid with AlignAck.
REQ-015 SHALL have port DecodeEnable, output, 1, high when the decoder may consume bits.
REQ-016 SHALL have ports CurComp (output, 3, current component) and CurBlk (output, 4, block index within the component's group in the MCU).
REQ-017 SHALL have ports McuX and McuY, output, W_POS each, position of the current MCU.
REQ-018 SHALL have port AlignReq, output, 1, level; requests byte alignment and RST marker consumption.
REQ-019 SHALL have port DcReset, output, 1, one-cycle pulse that clears the DC predictors.
REQ-020 SHALL have ports ScanDone (output, 1, level, scan complete) and RstError (output, 1, sticky, RST index mismatch).

Function
REQ-021 SHALL implement the states IDLE, RUN, ALIGN and DONE; all outputs SHALL be registered and update the cycle after the causing input.
REQ-022 ProcessInit SHALL take priority over every other input, force IDLE and set all outputs to their reset values.
REQ-023 In IDLE, ScanStart SHALL latch ScanComp, SampH, SampV, McuWidth, McuHeight and RestartInterval, zero all counters and the expected RST index, clear RstError, and enter RUN; if McuWidth==0 or McuHeight==0 it SHALL enter DONE instead.
REQ-024 ScanStart SHALL be accepted in IDLE and DONE only, clearing ScanDone; it SHALL be ignored in RUN and ALIGN, and later configuration changes SHALL have no effect until the next accepted ScanStart.
REQ-025 DecodeEnable SHALL be 1 in RUN only.
REQ-026 Block count per component SHALL be H*V, computed from the latched 2-bit fields (maximum 9); in a non-interleaved scan it SHALL be 1 regardless of sampling.
REQ-027 On BlockDone in RUN: if CurBlk+1 < the component's block count, CurBlk SHALL increment; otherwise CurBlk SHALL be set to 0 and, if CurComp+1 < ScanComp, CurComp SHALL increment; otherwise the MCU ends and CurComp SHALL be set to 0.
REQ-028 At MCU end, if McuX==McuWidth-1 and McuY==McuHeight-1, the block SHALL enter DONE with ScanDone=1; otherwise McuX SHALL increment, or wrap to 0 while McuY increments.
REQ-029 At a non-final MCU end with RestartInterval!=0, the restart counter SHALL increment; when it reaches RestartInterval it SHALL be cleared, the block SHALL enter ALIGN and AlignReq SHALL be set to 1.
REQ-030 When the final MCU coincides with a restart boundary, DONE SHALL take priority: no ALIGN and no AlignReq.
REQ-031 On AlignAck in ALIGN: if RstNum differs from the expected index, RstError SHALL be set; the expected index SHALL increment mod 8; AlignReq SHALL clear; DcReset SHALL pulse for one cycle; the block SHALL return to RUN.
REQ-032 BlockDone SHALL be ignored in IDLE, ALIGN and DONE; AlignAck SHALL be ignored outside ALIGN, including when it arrives together with BlockDone in RUN.

Reset
REQ-033 While rst==0 at a rising clk edge, the block SHALL enter IDLE with all outputs, counters and the expected RST index set to 0.
REQ-034 Reset SHALL abort any in-progress scan, ALIGN included, with no residual DcReset pulse.

Verification
REQ-035 Three-component 4:2:0 scan (SampH=SampV={2,1,1}, comp0 =2) with McuWidth=2, McuHeight=1, RestartInterval=0: twelve BlockDone pulses produce CurComp/CurBlk 0/0,0/1,0/2,0/3,1/0,2/0 twice; McuX goes 0 to 1; ScanDone=1 after the 12th pulse.
REQ-036 One component, McuWidth=4, McuHeight=1, RestartInterval=2: after the 2nd BlockDone, AlignReq=1 and DecodeEnable=0, and an extra BlockDone is ignored; AlignAck with RstNum=0 gives DcReset for one cycle and RUN; at the 4th block the block enters DONE with no AlignReq.
REQ-037 The same setup with AlignAck and RstNum=3 sets RstError=1, which holds until the next ScanStart.
REQ-038 Non-interleaved scan (ScanComp=1, SampH0=2): each BlockDone advances McuX and CurBlk stays 0.
REQ-039 ProcessInit or rst=0 during ALIGN gives IDLE with AlignReq=0, DcReset=0 and McuX=McuY=0 the next cycle.
REQ-040 ScanStart with McuWidth=0 gives ScanDone=1 and DecodeEnable=0 the next cycle.

Source files
------------

// File: rtl/aq_djpeg_mcu_seq.sv
// JPEG scan MCU/block sequencer: walks component/block/MCU order and restart intervals.
// Outputs registered (1-cycle latency); BlockDone ignored outside RUN, AlignReq held until AlignAck.
module aq_djpeg_mcu_seq #(
    parameter int COMP_MAX = 3,
    parameter int W_POS    = 12,
    parameter int W_RST    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ProcessInit,
    input  logic                  ScanStart,
    input  logic [2:0]            ScanComp,
    input  logic [2*COMP_MAX-1:0] SampH,
    input  logic [2*COMP_MAX-1:0] SampV,
    input  logic [W_POS-1:0]      McuWidth,
    input  logic [W_POS-1:0]      McuHeight,
    input  logic [W_RST-1:0]      RestartInterval,
    input  logic                  BlockDone,
    input  logic                  AlignAck,
    input  logic [2:0]            RstNum,
    output logic                  DecodeEnable,
    output logic [2:0]            CurComp,
    output logic [3:0]            CurBlk,
    output logic [W_POS-1:0]      McuX,
    output logic [W_POS-1:0]      McuY,
    output logic                  AlignReq,
    output logic                  DcReset,
    output logic                  ScanDone,
    output logic                  RstError
);

    typedef enum logic [1:0] {IDLE, RUN, ALIGN, DONE} state_t;

    state_t                state, stateNxt;
    logic [2:0]            cfgComp, cfgCompNxt;
    logic [2*COMP_MAX-1:0] cfgH, cfgHNxt, cfgV, cfgVNxt;
    logic [W_POS-1:0]      cfgW, cfgWNxt, cfgHt, cfgHtNxt;
    logic [W_RST-1:0]      cfgRi, cfgRiNxt, rstCnt, rstCntNxt;
    logic [2:0]            expRst, expRstNxt;
    logic [2:0]            curCompNxt;
    logic [3:0]            curBlkNxt;
    logic [W_POS-1:0]      mcuXNxt, mcuYNxt;
    logic                  alignReqNxt, dcResetNxt, scanDoneNxt, rstErrorNxt, decodeEnableNxt;

    logic [1:0]            sampH, sampV;
    logic [3:0]            blkCnt;
    logic                  lastMcu;
    logic [W_RST-1:0]      rstCntInc;

    // Sampling factors of the component currently being decoded.
    always_comb begin
        sampH = 2'd0;
        sampV = 2'd0;
        for (int i = 0; i < COMP_MAX; i++) begin
            if (CurComp == 3'(i)) begin
                sampH = cfgH[2*i +: 2];
                sampV = cfgV[2*i +: 2];
            end
        end
    end

    assign blkCnt    = (cfgComp == 3'd1) ? 4'd1 : ({2'b00, sampH} * {2'b00, sampV});
    assign lastMcu   = (McuX == cfgW - W_POS'(1)) && (McuY == cfgHt - W_POS'(1));
    assign rstCntInc = rstCnt + W_RST'(1);

    always_comb begin
        stateNxt    = state;
        cfgCompNxt  = cfgComp;
        cfgHNxt     = cfgH;
        cfgVNxt     = cfgV;
        cfgWNxt     = cfgW;
        cfgHtNxt    = cfgHt;
        cfgRiNxt    = cfgRi;
        rstCntNxt   = rstCnt;
        expRstNxt   = expRst;
        curCompNxt  = CurComp;
        curBlkNxt   = CurBlk;
        mcuXNxt     = McuX;
        mcuYNxt     = McuY;
        alignReqNxt = AlignReq;
        dcResetNxt  = 1'b0;
        scanDoneNxt = ScanDone;
        rstErrorNxt = RstError;

        case (state)
            IDLE, DONE: begin
                if (ScanStart) begin
                    cfgCompNxt  = ScanComp;
                    cfgHNxt     = SampH;
                    cfgVNxt     = SampV;
                    cfgWNxt     = McuWidth;
                    cfgHtNxt    = McuHeight;
                    cfgRiNxt    = RestartInterval;
                    rstCntNxt   = '0;
                    expRstNxt   = 3'd0;
                    curCompNxt  = 3'd0;
                    curBlkNxt   = 4'd0;
                    mcuXNxt     = '0;
                    mcuYNxt     = '0;
                    rstErrorNxt = 1'b0;
                    if (McuWidth == '0 || McuHeight == '0) begin
                        stateNxt    = DONE;
                        scanDoneNxt = 1'b1;
                    end else begin
                        stateNxt    = RUN;
                        scanDoneNxt = 1'b0;
                    end
                end
            end
            RUN: begin
                if (BlockDone) begin
                    if ({1'b0, CurBlk} + 5'd1 < {1'b0, blkCnt}) begin
                        curBlkNxt = CurBlk + 4'd1;
                    end else begin
                        curBlkNxt = 4'd0;
                        if ({1'b0, CurComp} + 4'd1 < {1'b0, cfgComp}) begin
                            curCompNxt = CurComp + 3'd1;
                        end else begin
                            curCompNxt = 3'd0;
                            if (lastMcu) begin
                                // Final MCU wins over any coinciding restart boundary.
                                stateNxt    = DONE;
                                scanDoneNxt = 1'b1;
                            end else begin
                                if (McuX == cfgW - W_POS'(1)) begin
                                    mcuXNxt = '0;
                                    mcuYNxt = McuY + W_POS'(1);
                                end else begin
                                    mcuXNxt = McuX + W_POS'(1);
                                end
                                if (cfgRi != '0) begin
                                    if (rstCntInc == cfgRi) begin
                                        rstCntNxt   = '0;
                                        stateNxt    = ALIGN;
                                        alignReqNxt = 1'b1;
                                    end else begin
                                        rstCntNxt = rstCntInc;
                                    end
                                end
                            end
                        end
                    end
                end
            end
            ALIGN: begin
                if (AlignAck) begin
                    if (RstNum != expRst) rstErrorNxt = 1'b1;
                    expRstNxt   = expRst + 3'd1;
                    alignReqNxt = 1'b0;
                    dcResetNxt  = 1'b1;
                    stateNxt    = RUN;
                end
            end
            default: stateNxt = IDLE;
        endcase

        decodeEnableNxt = (stateNxt == RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst || ProcessInit) begin
            state        <= IDLE;
            cfgComp      <= '0;
            cfgH         <= '0;
            cfgV         <= '0;
            cfgW         <= '0;
            cfgHt        <= '0;
            cfgRi        <= '0;
            rstCnt       <= '0;
            expRst       <= '0;
            CurComp      <= '0;
            CurBlk       <= '0;
            McuX         <= '0;
            McuY         <= '0;
            AlignReq     <= 1'b0;
            DcReset      <= 1'b0;
            ScanDone     <= 1'b0;
            RstError     <= 1'b0;
            DecodeEnable <= 1'b0;
        end else begin
            state        <= stateNxt;
            cfgComp      <= cfgCompNxt;
            cfgH         <= cfgHNxt;
            cfgV         <= cfgVNxt;
            cfgW         <= cfgWNxt;
            cfgHt        <= cfgHtNxt;
            cfgRi        <= cfgRiNxt;
            rstCnt       <= rstCntNxt;
            expRst       <= expRstNxt;
            CurComp      <= curCompNxt;
            CurBlk       <= curBlkNxt;
            McuX         <= mcuXNxt;
            McuY         <= mcuYNxt;
            AlignReq     <= alignReqNxt;
            DcReset      <= dcResetNxt;
            ScanDone     <= scanDoneNxt;
            RstError     <= rstErrorNxt;
            DecodeEnable <= decodeEnableNxt;
        end
    end

endmodule

// File: tb/tb_aq_djpeg_mcu_seq.sv
// Randomized + directed bench for aq_djpeg_mcu_seq against a block-list reference model.
module tb_aq_djpeg_mcu_seq;

    logic        clk = 1'b0;
    logic        rst, ProcessInit, ScanStart, BlockDone, AlignAck;
    logic [2:0]  ScanComp, RstNum;
    logic [5:0]  SampH, SampV;
    logic [11:0] McuWidth, McuHeight;
    logic [15:0] RestartInterval;
    logic        DecodeEnable, AlignReq, DcReset, ScanDone, RstError;
    logic [2:0]  CurComp;
    logic [3:0]  CurBlk;
    logic [11:0] McuX, McuY;

    aq_djpeg_mcu_seq dut (
        .clk(clk), .rst(rst), .ProcessInit(ProcessInit), .ScanStart(ScanStart),
        .ScanComp(ScanComp), .SampH(SampH), .SampV(SampV), .McuWidth(McuWidth),
        .McuHeight(McuHeight), .RestartInterval(RestartInterval), .BlockDone(BlockDone),
        .AlignAck(AlignAck), .RstNum(RstNum), .DecodeEnable(DecodeEnable),
        .CurComp(CurComp), .CurBlk(CurBlk), .McuX(McuX), .McuY(McuY),
        .AlignReq(AlignReq), .DcReset(DcReset), .ScanDone(ScanDone), .RstError(RstError)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // Reference model: the whole scan is flattened into an ordered list of blocks.
    typedef struct {
        int c, b, x, y;
        bit alignAfter, last;
    } ent_t;

    ent_t blist[$];
    int   pos, eState, ec, eb, ex, ey, eExp;
    bit   eAlign, eDc, eDone, eErr;

    task automatic build_list(input int nc, input logic [5:0] sh, input logic [5:0] sv,
                              input int w, input int ht, input int ri);
        ent_t e;
        int   nb, mcu;
        blist.delete();
        for (int y = 0; y < ht; y++)
            for (int x = 0; x < w; x++)
                for (int c = 0; c < nc; c++) begin
                    nb = (nc == 1) ? 1 : int'(sh[2*c +: 2]) * int'(sv[2*c +: 2]);
                    for (int b = 0; b < nb; b++) begin
                        mcu = y * w + x + 1;
                        e.c = c; e.b = b; e.x = x; e.y = y;
                        e.last = (c == nc - 1) && (b == nb - 1) && (mcu == w * ht);
                        e.alignAfter = (c == nc - 1) && (b == nb - 1) && !e.last &&
                                       (ri != 0) && (mcu % ri == 0);
                        blist.push_back(e);
                    end
                end
    endtask

    task automatic load_pos();
        ec = blist[pos].c; eb = blist[pos].b; ex = blist[pos].x; ey = blist[pos].y;
    endtask

    task automatic model_update();
        bit al;
        eDc = 1'b0;
        if (!rst || ProcessInit) begin
            eState = 0; ec = 0; eb = 0; ex = 0; ey = 0;
            eAlign = 0; eDone = 0; eErr = 0; eExp = 0;
        end else begin
            case (eState)
                0, 3: if (ScanStart) begin
                    eExp = 0; eErr = 0; eDone = 0; ec = 0; eb = 0; ex = 0; ey = 0; pos = 0;
                    if (McuWidth == 0 || McuHeight == 0) begin
                        eState = 3; eDone = 1;
                    end else begin
                        build_list(int'(ScanComp), SampH, SampV, int'(McuWidth),
                                   int'(McuHeight), int'(RestartInterval));
                        eState = 1;
                    end
                end
                1: if (BlockDone) begin
                    if (blist[pos].last) begin
                        eState = 3; eDone = 1; ec = 0; eb = 0;
                    end else begin
                        al = blist[pos].alignAfter;
                        pos++;
                        load_pos();
                        if (al) begin eState = 2; eAlign = 1; end
                    end
                end
                2: if (AlignAck) begin
                    if (int'(RstNum) != eExp) eErr = 1;
                    eExp = (eExp + 1) % 8;
                    eAlign = 0; eDc = 1; eState = 1;
                end
                default: eState = 0;
            endcase
        end
    endtask

    task automatic compare_all();
        check_val("DecodeEnable", 32'(DecodeEnable), 32'(eState == 1));
        check_val("CurComp", 32'(CurComp), 32'(ec));
        check_val("CurBlk", 32'(CurBlk), 32'(eb));
        check_val("McuX", 32'(McuX), 32'(ex));
        check_val("McuY", 32'(McuY), 32'(ey));
        check_val("AlignReq", 32'(AlignReq), 32'(eAlign));
        check_val("DcReset", 32'(DcReset), 32'(eDc));
        check_val("ScanDone", 32'(ScanDone), 32'(eDone));
        check_val("RstError", 32'(RstError), 32'(eErr));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
        ProcessInit = 0; ScanStart = 0; BlockDone = 0; AlignAck = 0;
    endtask

    task automatic set_cfg(input int nc, input logic [5:0] sh, input logic [5:0] sv,
                           input int w, input int ht, input int ri);
        ScanComp = 3'(nc); SampH = sh; SampV = sv;
        McuWidth = 12'(w); McuHeight = 12'(ht); RestartInterval = 16'(ri);
    endtask

    task automatic start();   ScanStart = 1; tick(); endtask
    task automatic bd();      BlockDone = 1; tick(); endtask
    task automatic ack(input int rn); AlignAck = 1; RstNum = 3'(rn); tick(); endtask

    int tabC[6] = '{0, 0, 0, 0, 1, 2};
    int tabB[6] = '{0, 1, 2, 3, 0, 0};

    initial begin
        rst = 0; ProcessInit = 0; ScanStart = 0; BlockDone = 0; AlignAck = 0; RstNum = 0;
        set_cfg(1, 6'b010101, 6'b010101, 1, 1, 0);
        tick(); tick();
        check_val("reset_DecodeEnable", 32'(DecodeEnable), 0);
        check_val("reset_McuX", 32'(McuX), 0);
        rst = 1;
        tick();

        // 4:2:0 three-component scan, two MCUs
        set_cfg(3, 6'b010110, 6'b010110, 2, 1, 0);
        start();
        for (int k = 1; k <= 12; k++) begin
            bd();
            if (k < 12) begin
                check_val("420_CurComp", 32'(CurComp), 32'(tabC[k % 6]));
                check_val("420_CurBlk", 32'(CurBlk), 32'(tabB[k % 6]));
                check_val("420_McuX", 32'(McuX), 32'(k / 6));
            end
        end
        check_val("420_ScanDone", 32'(ScanDone), 1);

        // restart interval 2 over 4 MCUs, correct RST index
        set_cfg(1, 6'b010101, 6'b010101, 4, 1, 2);
        start();
        bd(); bd();
        check_val("ri_AlignReq", 32'(AlignReq), 1);
        check_val("ri_DecodeEnable", 32'(DecodeEnable), 0);
        bd();
        check_val("ri_ignoredBlk_McuX", 32'(McuX), 2);
        ack(0);
        check_val("ri_DcReset", 32'(DcReset), 1);
        check_val("ri_run", 32'(DecodeEnable), 1);
        tick();
        check_val("ri_DcReset_pulse", 32'(DcReset), 0);
        bd(); bd();
        check_val("ri_final_Done", 32'(ScanDone), 1);
        check_val("ri_final_noAlign", 32'(AlignReq), 0);

        // wrong RST index sets a sticky error
        start();
        bd(); bd();
        ack(3);
        check_val("rsterr_set", 32'(RstError), 1);
        bd(); bd();
        check_val("rsterr_hold", 32'(RstError), 1);
        start();
        check_val("rsterr_clear", 32'(RstError), 0);

        // non-interleaved scan ignores sampling factors
        set_cfg(1, 6'b010110, 6'b010101, 3, 1, 0);
        start();
        bd();
        check_val("ni_McuX", 32'(McuX), 1);
        check_val("ni_CurBlk", 32'(CurBlk), 0);

        // ProcessInit and rst during ALIGN
        set_cfg(1, 6'b010101, 6'b010101, 4, 1, 1);
        start(); bd();
        check_val("pi_inAlign", 32'(AlignReq), 1);
        ProcessInit = 1; tick();
        check_val("pi_AlignReq", 32'(AlignReq), 0);
        check_val("pi_McuX", 32'(McuX), 0);
        start(); bd();
        rst = 0; tick(); rst = 1;
        check_val("rst_AlignReq", 32'(AlignReq), 0);
        check_val("rst_DcReset", 32'(DcReset), 0);

        // zero-width scan completes immediately
        set_cfg(2, 6'b010101, 6'b010101, 0, 2, 0);
        start();
        check_val("zw_ScanDone", 32'(ScanDone), 1);
        check_val("zw_DecodeEnable", 32'(DecodeEnable), 0);

        // randomized traffic, config lines churn every cycle
        for (int n = 0; n < 6000; n++) begin
            ScanComp = 3'($urandom_range(1, 3));
            for (int c = 0; c < 3; c++) begin
                SampH[2*c +: 2] = 2'($urandom_range(1, 3));
                SampV[2*c +: 2] = 2'($urandom_range(1, 3));
            end
            McuWidth        = 12'($urandom_range(0, 4));
            McuHeight       = 12'($urandom_range(0, 3));
            RestartInterval = 16'($urandom_range(0, 3));
            ScanStart   = ($urandom_range(0, 19) < ((eState == 0 || eState == 3) ? 8 : 1));
            BlockDone   = ($urandom_range(0, 1) == 1);
            AlignAck    = ($urandom_range(0, 2) == 0);
            RstNum      = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'(eExp);
            ProcessInit = ($urandom_range(0, 499) == 0);
            rst         = ($urandom_range(0, 499) != 0);
            tick();
        end
        rst = 1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
